// File: rtl/if_stage_fq.sv
// Instruction-fetch stage with a decoupling fetch queue between the icache port
// and the IF/ID register; one outstanding request, redirects squash wrong-path work.
module if_stage_fq #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                FQ_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      ic_req,
   output logic [ADDR_W-1:0]         ic_addr,
   input  logic                      ic_gnt,
   input  logic                      ic_rdy,
   input  logic [DATA_W-1:0]         ic_insn,
   input  logic                      stall,
   input  logic                      flush,
   input  logic [ADDR_W-1:0]         new_pc,
   input  logic                      br_taken,
   input  logic [ADDR_W-1:0]         br_addr,
   output logic [ADDR_W-1:0]         pc,
   output logic [ADDR_W-1:0]         if_pc,
   output logic [DATA_W-1:0]         if_insn,
   output logic                      if_en,
   output logic [$clog2(FQ_DEPTH):0] fq_count,
   output logic [1:0]                o_dbg_state
);

   localparam int PW = $clog2(FQ_DEPTH);
   localparam int CW = PW + 1;

   // Icache handshake: a request transfers in the cycle ic_req & ic_gnt are both
   // high; exactly one response (ic_rdy) follows some cycles later, and a new
   // request is only raised once that response has been consumed or discarded.
   typedef enum logic [1:0] {
      S_START = 2'd0,
      S_IDLE  = 2'd1,
      S_WAIT  = 2'd2,
      S_DROP  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   r_req_pc;
   logic [ADDR_W-1:0]   r_if_pc;
   logic [DATA_W-1:0]   r_if_insn;
   logic                r_if_en;

   logic [ADDR_W-1:0]   r_fq_pc   [FQ_DEPTH];
   logic [DATA_W-1:0]   r_fq_insn [FQ_DEPTH];
   logic [PW-1:0]       r_wptr;
   logic [PW-1:0]       r_rptr;
   logic [CW-1:0]       r_count;

   logic                w_redir;
   logic [ADDR_W-1:0]   w_target;
   logic                w_not_full;
   logic                w_fq_empty;
   logic                w_issue;
   logic                w_grant;
   logic                w_deliver;
   logic                w_bypass;
   logic                w_push;
   logic                w_pop;

   assign w_redir    = flush | br_taken;
   assign w_target   = flush ? new_pc : br_addr;
   assign w_not_full = (r_count < CW'(FQ_DEPTH));
   assign w_fq_empty = (r_count == '0);
   assign w_grant    = w_issue & ic_gnt;

   // An empty queue with ID ready lets the response skip the FIFO entirely.
   assign w_bypass   = w_deliver & ~stall & w_fq_empty;
   assign w_push     = w_deliver & ~w_bypass;
   assign w_pop      = ~stall & ~w_redir & ~w_fq_empty;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_START;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_START: w_state_nxt = S_IDLE;
         S_IDLE: begin
            if (w_grant) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (ic_rdy)       w_state_nxt = S_IDLE;
            else if (w_redir) w_state_nxt = S_DROP;
         end
         S_DROP: begin
            if (ic_rdy) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_START;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      w_issue   = 1'b0;
      w_deliver = 1'b0;
      case (r_state)
         S_IDLE: w_issue   = w_not_full & ~w_redir;
         S_WAIT: w_deliver = ic_rdy & ~w_redir;
         default: begin
            w_issue   = 1'b0;
            w_deliver = 1'b0;
         end
      endcase
   end

   // ---------------- Fetch PC ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc     <= RESET_PC;
         r_req_pc <= '0;
      end else begin
         if (w_redir) begin
            r_pc <= w_target;
         end else if (w_grant) begin
            r_pc <= r_pc + ADDR_W'(4);
         end
         if (w_grant) begin
            r_req_pc <= r_pc;
         end
      end
   end

   // ---------------- Fetch queue storage ----------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fq_pc[r_wptr]   <= r_req_pc;
         r_fq_insn[r_wptr] <= ic_insn;
      end
   end

   // Occupancy never overflows: a grant needs a free slot and nothing else is
   // pushed while that single request is outstanding.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (w_redir) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------- IF/ID register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_if_pc   <= '0;
         r_if_insn <= '0;
         r_if_en   <= 1'b0;
      end else if (w_redir) begin
         r_if_insn <= '0;
         r_if_en   <= 1'b0;
      end else if (!stall) begin
         if (!w_fq_empty) begin
            r_if_pc   <= r_fq_pc[r_rptr];
            r_if_insn <= r_fq_insn[r_rptr];
            r_if_en   <= 1'b1;
         end else if (w_deliver) begin
            r_if_pc   <= r_req_pc;
            r_if_insn <= ic_insn;
            r_if_en   <= 1'b1;
         end else begin
            r_if_insn <= '0;
            r_if_en   <= 1'b0;
         end
      end
   end

   assign ic_req      = w_issue;
   assign ic_addr     = r_pc;
   assign pc          = r_pc;
   assign if_pc       = r_if_pc;
   assign if_insn     = r_if_insn;
   assign if_en       = r_if_en;
   assign fq_count    = r_count;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_if_stage_fq.sv
// Bench for if_stage_fq: directed scenarios then random traffic, all checked
// against a transaction-level model (outstanding flag + expected FIFO queue).
module tb_if_stage_fq;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam logic [AW-1:0] RST_PC = 32'h0;

   logic          clk;
   logic          reset;
   logic          ic_req;
   logic [AW-1:0] ic_addr;
   logic          ic_gnt;
   logic          ic_rdy;
   logic [DW-1:0] ic_insn;
   logic          stall;
   logic          flush;
   logic [AW-1:0] new_pc;
   logic          br_taken;
   logic [AW-1:0] br_addr;
   logic [AW-1:0] pc;
   logic [AW-1:0] if_pc;
   logic [DW-1:0] if_insn;
   logic          if_en;
   logic [$clog2(DEPTH):0] fq_count;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   if_stage_fq #(
      .ADDR_W(AW), .DATA_W(DW), .FQ_DEPTH(DEPTH), .RESET_PC(RST_PC)
   ) dut (
      .clk(clk), .reset(reset),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rdy(ic_rdy), .ic_insn(ic_insn),
      .stall(stall), .flush(flush), .new_pc(new_pc), .br_taken(br_taken), .br_addr(br_addr),
      .pc(pc), .if_pc(if_pc), .if_insn(if_insn), .if_en(if_en), .fq_count(fq_count),
      .o_dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [AW+DW-1:0] exp_q[$];
   bit               m_started;
   bit               m_busy;
   bit               m_drop;
   logic [AW-1:0]    m_pc;
   logic [AW-1:0]    m_req_pc;
   logic [AW-1:0]    m_if_pc;
   logic [DW-1:0]    m_if_insn;
   bit               m_if_en;

   task automatic model_reset();
      exp_q.delete();
      m_started = 0; m_busy = 0; m_drop = 0;
      m_pc = RST_PC; m_req_pc = '0;
      m_if_pc = '0; m_if_insn = '0; m_if_en = 0;
   endtask

   function automatic bit exp_req();
      return m_started && !m_busy && (exp_q.size() < DEPTH) && !(flush || br_taken);
   endfunction

   task automatic model_step();
      bit               redir;
      bit               req;
      bit               deliver;
      logic [AW+DW-1:0] ent;
      logic [AW+DW-1:0] head;
      redir   = flush || br_taken;
      req     = exp_req();
      deliver = m_busy && !m_drop && ic_rdy && !redir;
      ent     = {m_req_pc, ic_insn};
      if (!m_started) begin
         m_started = 1;
      end else if (m_busy) begin
         if (ic_rdy) begin m_busy = 0; m_drop = 0; end
         else if (redir) m_drop = 1;
      end else if (req && ic_gnt) begin
         m_busy = 1; m_drop = 0; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
      end
      if (redir) begin
         m_pc = flush ? new_pc : br_addr;
         exp_q.delete();
         m_if_en = 0; m_if_insn = '0;
      end else if (!stall) begin
         if (exp_q.size() > 0) begin
            head = exp_q.pop_front();
            m_if_pc = head[AW+DW-1:DW]; m_if_insn = head[DW-1:0]; m_if_en = 1;
            if (deliver) exp_q.push_back(ent);
         end else if (deliver) begin
            m_if_pc = ent[AW+DW-1:DW]; m_if_insn = ent[DW-1:0]; m_if_en = 1;
         end else begin
            m_if_en = 0; m_if_insn = '0;
         end
      end else if (deliver) begin
         exp_q.push_back(ent);
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs();
      bit r;
      r = exp_req();
      chk("ic_req", 64'(ic_req), 64'(r));
      if (r) chk("ic_addr", 64'(ic_addr), 64'(m_pc));
      chk("pc", 64'(pc), 64'(m_pc));
      chk("if_en", 64'(if_en), 64'(m_if_en));
      chk("if_insn", 64'(if_insn), 64'(m_if_insn));
      if (m_if_en) chk("if_pc", 64'(if_pc), 64'(m_if_pc));
      chk("fq_count", 64'(fq_count), 64'(exp_q.size()));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"}, 64'(pc), 64'(RST_PC));
      chk({tag, "_if_pc"}, 64'(if_pc), 64'h0);
      chk({tag, "_if_insn"}, 64'(if_insn), 64'h0);
      chk({tag, "_if_en"}, 64'(if_en), 64'h0);
      chk({tag, "_fq_count"}, 64'(fq_count), 64'h0);
      chk({tag, "_ic_req"}, 64'(ic_req), 64'h0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      ic_gnt = 0; ic_rdy = 0; ic_insn = '0; stall = 0;
      flush = 0; new_pc = '0; br_taken = 0; br_addr = '0;
   endtask

   // Responsive icache: answers the cycle after a grant.
   task automatic auto_rdy();
      ic_rdy  = m_busy;
      ic_insn = $urandom;
   endtask

   task automatic cycle();
      @(negedge clk);
      chk_outputs();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      reset = 1;
      model_reset();
   endtask

   int  grants;
   bit  found;

   initial begin
      reset = 0;
      idle_inputs();
      model_reset();

      // Back-to-back fetch through the bypass path
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         ic_gnt = 1; auto_rdy();
         cycle();
      end
      chk("t1_fq_count", 64'(fq_count), 64'h0);

      // Stall fills the queue, release drains it in order
      apply_reset();
      grants = 0;
      for (int i = 0; i < 20; i++) begin
         ic_gnt = 1; stall = 1; auto_rdy();
         #1;
         if (ic_req && ic_gnt) grants++;
         cycle();
      end
      chk("t2_grants", 64'(grants), 64'd4);
      chk("t2_full", 64'(fq_count), 64'd4);
      chk("t2_req_off", 64'(ic_req), 64'h0);
      stall = 0;
      for (int k = 0; k < 4; k++) begin
         ic_gnt = 1; auto_rdy();
         cycle();
         chk("t2_drain_en", 64'(if_en), 64'h1);
         chk("t2_drain_pc", 64'(if_pc), 64'(k * 4));
      end

      // Flush while WAIT: response dropped, fetch restarts at target
      apply_reset();
      ic_gnt = 1; cycle();
      ic_gnt = 1; cycle();
      ic_gnt = 0; flush = 1; new_pc = 32'h100; cycle();
      flush = 0; cycle();
      ic_rdy = 1; ic_insn = 32'hdead_beef; cycle();
      chk("t3_dropped", 64'(if_en), 64'h0);
      ic_rdy = 0; ic_gnt = 1; #1;
      chk("t3_req", 64'(ic_req), 64'h1);
      chk("t3_addr", 64'(ic_addr), 64'h100);
      cycle();
      ic_rdy = 1; ic_insn = 32'h1234_5678; cycle();
      chk("t3_if_en", 64'(if_en), 64'h1);
      chk("t3_if_pc", 64'(if_pc), 64'h100);

      // Simultaneous flush and branch under stall: flush wins
      apply_reset();
      for (int i = 0; i < 6; i++) begin ic_gnt = 1; auto_rdy(); cycle(); end
      for (int i = 0; i < 6; i++) begin ic_gnt = 1; stall = 1; auto_rdy(); cycle(); end
      stall = 1; ic_rdy = 0; flush = 1; new_pc = 32'h200; br_taken = 1; br_addr = 32'h300;
      cycle();
      chk("t4_pc", 64'(pc), 64'h200);
      chk("t4_fq_count", 64'(fq_count), 64'h0);
      chk("t4_if_en", 64'(if_en), 64'h0);
      idle_inputs();
      for (int i = 0; i < 4; i++) begin ic_gnt = 1; auto_rdy(); cycle(); end

      // Response and branch in the same WAIT cycle
      apply_reset();
      ic_gnt = 1; cycle();
      ic_gnt = 1; cycle();
      ic_gnt = 0; ic_rdy = 1; ic_insn = 32'hcafe_f00d; br_taken = 1; br_addr = 32'h40;
      cycle();
      chk("t5_if_en", 64'(if_en), 64'h0);
      br_taken = 0; ic_rdy = 0; ic_gnt = 1; #1;
      chk("t5_req", 64'(ic_req), 64'h1);
      chk("t5_addr", 64'(ic_addr), 64'h40);
      cycle();

      // Asynchronous reset while WAIT with two queued entries
      apply_reset();
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         ic_gnt = 1; stall = 1; auto_rdy();
         cycle();
         if (exp_q.size() == 2 && m_busy && !m_drop) found = 1;
      end
      chk("t6_setup", 64'(found), 64'h1);
      chk("t6_pre_count", 64'(fq_count), 64'h2);
      #2;
      reset = 0;
      #1;
      chk_reset_vals("t6");
      model_reset();
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1;
      ic_rdy = 1; ic_insn = 32'hbad0_bad0;
      cycle();
      ic_rdy = 1; ic_gnt = 1; #1;
      chk("t6_req", 64'(ic_req), 64'h1);
      chk("t6_addr", 64'(ic_addr), 64'(RST_PC));
      cycle();
      ic_rdy = 0; ic_gnt = 0; cycle();
      chk("t6_stray", 64'(if_en), 64'h0);

      // Random traffic
      apply_reset();
      for (int i = 0; i < 600; i++) begin
         ic_gnt   = ($urandom_range(0, 3) != 0);
         ic_rdy   = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
         ic_insn  = $urandom;
         stall    = ($urandom_range(0, 3) == 0);
         flush    = ($urandom_range(0, 15) == 0);
         br_taken = ($urandom_range(0, 15) == 0);
         new_pc   = $urandom & 32'hffff_fffc;
         br_addr  = $urandom & 32'hffff_fffc;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
